boot_rom_arbiter: RTL
=====================

Name: boot_rom_arbiter

Overview:
- Shares the single-port SoC boot ROM between NB_MASTERS requesters, for example the FC instruction port, the FC data port and the debug/JTAG access path.
- Uses round-robin arbitration on a TCDM-style req/gnt/r_valid handshake.
- Drives the ROM chip-select and word address, and routes the 1-cycle-latency read data back to the granted master.
- Sits between the SoC interconnect boot-ROM slave port and the ROM macro.

Parameters:
- NB_MASTERS, 2, number of requesters (2..8).
- ROM_ADDR_WIDTH, 13, byte-address width of the ROM region; the ROM word address is [ROM_ADDR_WIDTH-1:2].
- DATA_WIDTH, 32, ROM word width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- mst_req_i  in  NB_MASTERS  request per master.
- mst_add_i  in  NB_MASTERS x 32  byte address per master.
- mst_wen_i  in  NB_MASTERS  1 = read, 0 = write (TCDM convention).
- mst_gnt_o  out  NB_MASTERS  grant, combinational in the request cycle.
- mst_r_valid_o  out  NB_MASTERS  response valid, one cycle after the grant.
- mst_r_opc_o  out  NB_MASTERS  response error: 1 = write attempt.
- mst_r_rdata_o  out  NB_MASTERS x DATA_WIDTH  response data.
- rom_csn_o  out  1  ROM chip select, active-low.
- rom_addr_o  out  ROM_ADDR_WIDTH-2  ROM word address.
- rom_rdata_i  in  DATA_WIDTH  ROM Q; valid one cycle after rom_csn_o is low.

Behaviour:
- Reset values:
  - rr_ptr = 0, so master 0 has highest priority first.
  - All mst_r_valid_o = 0 and all mst_r_opc_o = 0.
  - rom_csn_o = 1 while no request is present.
  - mst_r_rdata_o = 0.
- Arbitration:
  - At most one grant per cycle.
  - The winner is the first requesting master at or after rr_ptr, scanning upward with wrap-around.
  - mst_gnt_o[w] is asserted combinationally in the same cycle as mst_req_i[w]. Non-winners see gnt = 0 and must hold their request.
  - On every grant, rr_ptr is set to (w+1) mod NB_MASTERS. With no grant, rr_ptr holds.
- Granted read (wen = 1):
  - In the grant cycle: rom_csn_o = 0 and rom_addr_o = mst_add_i[w][ROM_ADDR_WIDTH-1:2].
  - Next cycle: mst_r_valid_o[w] = 1, r_opc = 0, mst_r_rdata_o[w] = rom_rdata_i.
- Granted write (wen = 0):
  - The write is accepted (gnt = 1) to avoid deadlock, but rom_csn_o stays 1.
  - Next cycle: r_valid = 1, r_opc = 1, rdata = 0.
- Address bits [31:ROM_ADDR_WIDTH] are ignored; region decode is done upstream.
- Throughput: one access per cycle. Back-to-back grants to the same or different masters are allowed, with no bubble between them.
- Response pipeline:
  - One stage of registered state: resp_valid, resp_idx, resp_err.
  - Outputs are decoded from this stage. mst_r_rdata_o is 0 for every master whose r_valid is 0.
- Simultaneous events:
  - A new grant and the previous response occur in the same cycle, with independent masters or the same master; both are honoured.
  - If all masters request every cycle, they are served in strict rotation: 0, 1, ..., N-1, 0, ...
- Reset mid-operation: any in-flight response is discarded (r_valid = 0 after reset) and rr_ptr returns to 0.
- rom_addr_o is 0 when no read is granted, which gives deterministic ROM inputs.

Decomposition:
- Package boot_rom_pkg holds:
  - the TCDM opcode constants OPC_OK = 1'b0 and OPC_ERR = 1'b1;
  - the response-stage struct typedef: valid, idx of width $clog2(NB_MASTERS), err.
- One sub-module, boot_rom_rr_arbiter:
  - contains the round-robin pointer register and the combinational priority scan;
  - outputs the one-hot grant and the winner index.
- The top level instantiates it and adds the ROM drive logic and the response stage.

Test Plan:
- Single read: master 0 issues req with add = 0x1A000010, wen = 1, and the ROM model returns 0xDEADBEEF. Required: gnt in the same cycle, rom_csn_o = 0, rom_addr_o = 0x004; next cycle r_valid[0] = 1, r_opc = 0, rdata = 0xDEADBEEF.
- Contention: masters 0 and 1 both request continuously for 4 cycles after reset. Required: grants in the order 0, 1, 0, 1, and each response arrives exactly 1 cycle after its grant with the correct data.
- Write error: master 1 issues wen = 0. Required: gnt = 1, rom_csn_o = 1; next cycle r_valid[1] = 1, r_opc[1] = 1, rdata = 0.
- Pointer fairness: master 1 is granted alone, then masters 0 and 1 request together. Required: master 0 wins, because rr_ptr wrapped to 0.
- Reset mid-flight: rst_ni is asserted low in the cycle after a grant. Required: no r_valid appears; after release, master 0 has priority and all outputs are at their reset values.
- Back-to-back from one master: 8 consecutive reads at addresses 0x0 to 0x1C. Required: rom_addr_o steps through 0 to 7 and there are 8 consecutive r_valid pulses with the matching data.

Source files
------------

// File: rtl/boot_rom_pkg.sv
// Shared types and constants for the boot ROM arbiter.
// MAX_MASTERS bounds the response-stage index width for all supported configurations.
package boot_rom_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_WIDTH   = $clog2(MAX_MASTERS);

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [IDX_WIDTH-1:0] idx;
    logic                 err;
  } resp_t;

endpackage

// File: rtl/boot_rom_rr_arbiter.sv
// Round-robin arbiter: scans upward from rr_ptr with wrap-around and grants one requester.
// The grant is combinational; the pointer moves just past the winner on every grant.
module boot_rom_rr_arbiter
  import boot_rom_pkg::*;
#(
  parameter  int NB_MASTERS = 2,
  localparam int IDX_W      = $clog2(NB_MASTERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NB_MASTERS-1:0] req,
  output logic [NB_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]      win_idx,
  output logic                  win_valid
);

  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [SUM_W-1:0] scan_sum;
  logic [IDX_W-1:0] scan_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (win_valid) begin
      rr_ptr <= (win_idx == IDX_W'(NB_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // The extra sum bit lets the wrap be a single subtract for non-power-of-two counts.
  always_comb begin
    gnt       = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NB_MASTERS; k++) begin
      scan_sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (scan_sum >= SUM_W'(NB_MASTERS)) begin
        scan_sum = scan_sum - SUM_W'(NB_MASTERS);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
    if (win_valid) begin
      gnt[win_idx] = 1'b1;
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_in_req : assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~req) == '0);

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares a single-port boot ROM between NB_MASTERS TCDM requesters with round-robin arbitration.
// Writes are granted but answered with an error response so no master can deadlock.
module boot_rom_arbiter
  import boot_rom_pkg::*;
#(
  parameter int NB_MASTERS     = 2,
  parameter int ROM_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NB_MASTERS-1:0]                 mst_req_i,
  input  logic [NB_MASTERS-1:0][31:0]           mst_add_i,
  input  logic [NB_MASTERS-1:0]                 mst_wen_i,
  output logic [NB_MASTERS-1:0]                 mst_gnt_o,
  output logic [NB_MASTERS-1:0]                 mst_r_valid_o,
  output logic [NB_MASTERS-1:0]                 mst_r_opc_o,
  output logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] mst_r_rdata_o,
  output logic                                  rom_csn_o,
  output logic [ROM_ADDR_WIDTH-3:0]             rom_addr_o,
  input  logic [DATA_WIDTH-1:0]                 rom_rdata_i
);

  localparam int IDX_W = $clog2(NB_MASTERS);

  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             win_read;
  logic             unused_addr_bits;
  resp_t            resp_d;
  resp_t            resp_q;

  boot_rom_rr_arbiter #(
    .NB_MASTERS (NB_MASTERS)
  ) u_rr_arbiter (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .req       (mst_req_i),
    .gnt       (mst_gnt_o),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // The ROM is only enabled for reads; the address is parked at zero otherwise.
  always_comb begin
    win_read   = win_valid && mst_wen_i[win_idx];
    rom_csn_o  = !win_read;
    rom_addr_o = win_read ? mst_add_i[win_idx][ROM_ADDR_WIDTH-1:2] : '0;
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = win_valid;
    if (win_valid) begin
      resp_d.idx = IDX_WIDTH'(win_idx);
      resp_d.err = mst_wen_i[win_idx] ? OPC_OK : OPC_ERR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // The ROM Q is visible only to the master that owns the pending response.
  always_comb begin
    mst_r_valid_o = '0;
    mst_r_opc_o   = '0;
    mst_r_rdata_o = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (resp_q.valid && (resp_q.idx == IDX_WIDTH'(i))) begin
        mst_r_valid_o[i] = 1'b1;
        mst_r_opc_o[i]   = resp_q.err;
        mst_r_rdata_o[i] = (resp_q.err == OPC_ERR) ? '0 : rom_rdata_i;
      end
    end
  end

  always_comb begin
    unused_addr_bits = 1'b0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      unused_addr_bits = unused_addr_bits ^ (^{mst_add_i[i][31:ROM_ADDR_WIDTH], mst_add_i[i][1:0]});
    end
  end

  a_csn_only_on_read : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                        !rom_csn_o |-> win_valid);

endmodule
